// File: rtl/datapath_regs_pkg.sv
// Shared definitions for the accumulator CPU register datapath: default widths,
// opcode field placement, opcode values and the ACC operation selector.
package datapath_regs_pkg;

   localparam int WORD_W_DEF = 16;
   localparam int ADDR_W_DEF = 12;
   localparam int OPC_W      = 4;
   localparam int OPC_LSB    = WORD_W_DEF - OPC_W;

   typedef enum logic [OPC_W-1:0] {
      OP_HALT = 4'd0,
      OP_CLA  = 4'd1,
      OP_CMA  = 4'd2,
      OP_INCA = 4'd3,
      OP_CLF  = 4'd4,
      OP_CMF  = 4'd5,
      OP_SFZ  = 4'd6,
      OP_ROR  = 4'd7,
      OP_ROL  = 4'd8,
      OP_ADD  = 4'd9,
      OP_ADI  = 4'd10,
      OP_STA  = 4'd11,
      OP_JMP  = 4'd12,
      OP_CALL = 4'd13,
      OP_JMPI = 4'd14,
      OP_ISZ  = 4'd15
   } opcode_e;

   typedef enum logic [2:0] {
      ACC_HOLD,
      ACC_CLR,
      ACC_CMP,
      ACC_INC,
      ACC_ROR,
      ACC_ROL,
      ACC_ADD
   } acc_op_e;

   // Collapses the ACC strobes into the single winning operation.
   function automatic acc_op_e acc_select(input logic lacc, input logic cacc,
                                          input logic iacc, input logic ror,
                                          input logic rol, input logic add);
      if (lacc)      return ACC_CLR;
      else if (cacc) return ACC_CMP;
      else if (iacc) return ACC_INC;
      else if (ror)  return ACC_ROR;
      else if (rol)  return ACC_ROL;
      else if (add)  return ACC_ADD;
      return ACC_HOLD;
   endfunction

endpackage

// File: rtl/datapath_regs_acc_unit.sv
// Accumulator and flag F: clear/complement/increment/rotate/add with carry into F.
module datapath_regs_acc_unit
   import datapath_regs_pkg::*;
#(
   parameter int WORD_W = WORD_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              c_TGPRACC,
   input  logic              c_LACC,
   input  logic              c_CACC,
   input  logic              c_IACC,
   input  logic              c_ROR,
   input  logic              c_ROL,
   input  logic              c_LF,
   input  logic              c_CF,
   input  logic [WORD_W-1:0] gpr,
   output logic [WORD_W-1:0] acc,
   output logic              f
);

   logic [WORD_W-1:0] acc_reg;
   logic [WORD_W-1:0] acc_next;
   logic              f_reg;
   logic              f_next;
   logic              op_flag;
   logic [WORD_W:0]   sum_add;
   logic [WORD_W:0]   sum_inc;
   acc_op_e           acc_op;

   assign sum_add = {1'b0, acc_reg} + {1'b0, gpr};
   assign sum_inc = {1'b0, acc_reg} + (WORD_W+1)'(1);
   assign acc_op  = acc_select(c_LACC, c_CACC, c_IACC, c_ROR, c_ROL, c_TGPRACC);

   // op_flag is what F would become from the ACC op alone; F strobes override it.
   always_comb begin
      acc_next = acc_reg;
      op_flag  = f_reg;
      case (acc_op)
         ACC_CLR: acc_next = '0;
         ACC_CMP: acc_next = ~acc_reg;
         ACC_INC: {op_flag, acc_next} = sum_inc;
         ACC_ROR: begin
            acc_next = {f_reg, acc_reg[WORD_W-1:1]};
            op_flag  = acc_reg[0];
         end
         ACC_ROL: begin
            acc_next = {acc_reg[WORD_W-2:0], f_reg};
            op_flag  = acc_reg[WORD_W-1];
         end
         ACC_ADD: {op_flag, acc_next} = sum_add;
         default: ;
      endcase
      if (c_LF)      f_next = 1'b0;
      else if (c_CF) f_next = ~f_reg;
      else           f_next = op_flag;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         acc_reg <= '0;
         f_reg   <= 1'b0;
      end else begin
         acc_reg <= acc_next;
         f_reg   <= f_next;
      end
   end

   assign acc = acc_reg;
   assign f   = f_reg;

endmodule

// File: rtl/datapath_regs.sv
// Register datapath of the accumulator CPU: PC, MAR, GPR, OPR here, ACC/F in the
// acc unit. Every strobe acts at the next rising edge using pre-edge sources.
module datapath_regs
   import datapath_regs_pkg::*;
#(
   parameter int WORD_W = WORD_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              c_IPC,
   input  logic              c_TGPRaPC,
   input  logic              TMARaPC,
   input  logic              c_TPCaMAR,
   input  logic              c_TGPRaMAR,
   input  logic              c_TGPRaOPR,
   input  logic              c_TMaGPR,
   input  logic              c_TACCaGPR,
   input  logic              c_TPCaGPR,
   input  logic              c_IGPR,
   input  logic              c_w,
   input  logic              c_r,
   input  logic              c_TGPRACC,
   input  logic              c_LACC,
   input  logic              c_CACC,
   input  logic              c_IACC,
   input  logic              c_ROR,
   input  logic              c_ROL,
   input  logic              c_LF,
   input  logic              c_CF,
   output logic [OPC_W-1:0]  c_OPR,
   output logic              c_F,
   output logic              c_Z,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [WORD_W-1:0] mem_wdata,
   output logic              mem_we,
   output logic              mem_re,
   input  logic [WORD_W-1:0] mem_rdata,
   output logic [WORD_W-1:0] acc_q,
   output logic [ADDR_W-1:0] pc_q
);

   logic [ADDR_W-1:0] pc_reg,  pc_next;
   logic [ADDR_W-1:0] mar_reg, mar_next;
   logic [WORD_W-1:0] gpr_reg, gpr_next;
   logic [OPC_W-1:0]  opr_reg, opr_next;
   logic [WORD_W-1:0] acc_val;

   always_comb begin
      pc_next = pc_reg;
      if (c_TGPRaPC)    pc_next = gpr_reg[ADDR_W-1:0];
      else if (TMARaPC) pc_next = mar_reg;
      else if (c_IPC)   pc_next = pc_reg + ADDR_W'(1);

      mar_next = mar_reg;
      if (c_TGPRaMAR)     mar_next = gpr_reg[ADDR_W-1:0];
      else if (c_TPCaMAR) mar_next = pc_reg;

      // mem_rdata is asynchronous on MAR, so a read lands in GPR at the request edge.
      gpr_next = gpr_reg;
      if (c_TMaGPR)        gpr_next = mem_rdata;
      else if (c_TACCaGPR) gpr_next = acc_val;
      else if (c_TPCaGPR)  gpr_next = WORD_W'(pc_reg);
      else if (c_IGPR)     gpr_next = gpr_reg + WORD_W'(1);

      opr_next = c_TGPRaOPR ? gpr_reg[WORD_W-1 -: OPC_W] : opr_reg;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc_reg  <= '0;
         mar_reg <= '0;
         gpr_reg <= '0;
         opr_reg <= '0;
      end else begin
         pc_reg  <= pc_next;
         mar_reg <= mar_next;
         gpr_reg <= gpr_next;
         opr_reg <= opr_next;
      end
   end

   datapath_regs_acc_unit #(
      .WORD_W(WORD_W)
   ) u_acc_unit (
      .clk       (clk),
      .rst       (rst),
      .c_TGPRACC (c_TGPRACC),
      .c_LACC    (c_LACC),
      .c_CACC    (c_CACC),
      .c_IACC    (c_IACC),
      .c_ROR     (c_ROR),
      .c_ROL     (c_ROL),
      .c_LF      (c_LF),
      .c_CF      (c_CF),
      .gpr       (gpr_reg),
      .acc       (acc_val),
      .f         (c_F)
   );

   assign c_OPR     = opr_reg;
   assign c_Z       = (gpr_reg == '0);
   assign mem_addr  = mar_reg;
   assign mem_wdata = gpr_reg;
   assign mem_we    = c_w;
   assign mem_re    = c_r;
   assign acc_q     = acc_val;
   assign pc_q      = pc_reg;

endmodule

// File: tb/tb_datapath_regs.sv
// Bench for datapath_regs: arithmetic reference model checked every cycle, a RAM
// kept in the bench, directed scenarios with literal expectations, random strobes.
module tb_datapath_regs;

   localparam int B_IPC = 0,  B_TGPC = 1,  B_TMPC = 2,  B_TPMAR = 3, B_TGMAR = 4;
   localparam int B_TOPR = 5, B_TMG = 6,   B_TAG = 7,   B_TPG = 8,   B_IGPR = 9;
   localparam int B_W = 10,   B_R = 11,    B_ADD = 12,  B_LACC = 13, B_CACC = 14;
   localparam int B_IACC = 15, B_ROR = 16, B_ROL = 17,  B_LF = 18,   B_CF = 19;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic [19:0] strb = '0;

   logic [3:0]  c_OPR;
   logic        c_F, c_Z, mem_we, mem_re;
   logic [11:0] mem_addr, pc_q;
   logic [15:0] mem_wdata, mem_rdata, acc_q;
   logic [15:0] ram [0:4095];

   int tests = 0;
   int fails = 0;
   logic chk_en = 1'b0;
   int m_pc = 0, m_mar = 0, m_gpr = 0, m_opr = 0, m_acc = 0, m_f = 0;

   always #5 clk = ~clk;

   assign mem_rdata = ram[mem_addr];

   datapath_regs dut (
      .clk(clk), .rst(rst),
      .c_IPC(strb[B_IPC]), .c_TGPRaPC(strb[B_TGPC]), .TMARaPC(strb[B_TMPC]),
      .c_TPCaMAR(strb[B_TPMAR]), .c_TGPRaMAR(strb[B_TGMAR]), .c_TGPRaOPR(strb[B_TOPR]),
      .c_TMaGPR(strb[B_TMG]), .c_TACCaGPR(strb[B_TAG]), .c_TPCaGPR(strb[B_TPG]),
      .c_IGPR(strb[B_IGPR]), .c_w(strb[B_W]), .c_r(strb[B_R]),
      .c_TGPRACC(strb[B_ADD]), .c_LACC(strb[B_LACC]), .c_CACC(strb[B_CACC]),
      .c_IACC(strb[B_IACC]), .c_ROR(strb[B_ROR]), .c_ROL(strb[B_ROL]),
      .c_LF(strb[B_LF]), .c_CF(strb[B_CF]),
      .c_OPR(c_OPR), .c_F(c_F), .c_Z(c_Z),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
      .mem_rdata(mem_rdata), .acc_q(acc_q), .pc_q(pc_q)
   );

   function automatic logic [19:0] m(input int b);
      logic [19:0] v;
      v = '0;
      v[b] = 1'b1;
      return v;
   endfunction

   function automatic void chk(input string nm, input int act, input int exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endfunction

   // Reference model: register-transfer rules written as plain integer arithmetic.
   task automatic model_step();
      int npc, nmar, ngpr, nopr, nacc, nf, cf, s;
      npc = m_pc; nmar = m_mar; ngpr = m_gpr; nopr = m_opr; nacc = m_acc; cf = m_f;
      if (strb[B_TGPC])       npc = m_gpr % 4096;
      else if (strb[B_TMPC])  npc = m_mar;
      else if (strb[B_IPC])   npc = (m_pc + 1) % 4096;
      if (strb[B_TGMAR])      nmar = m_gpr % 4096;
      else if (strb[B_TPMAR]) nmar = m_pc;
      if (strb[B_TMG])        ngpr = int'(ram[m_mar]);
      else if (strb[B_TAG])   ngpr = m_acc;
      else if (strb[B_TPG])   ngpr = m_pc;
      else if (strb[B_IGPR])  ngpr = (m_gpr + 1) % 65536;
      if (strb[B_TOPR])       nopr = m_gpr / 4096;
      if (strb[B_LACC])       nacc = 0;
      else if (strb[B_CACC])  nacc = 65535 - m_acc;
      else if (strb[B_IACC]) begin s = m_acc + 1; nacc = s % 65536; cf = s / 65536; end
      else if (strb[B_ROR]) begin cf = m_acc % 2; nacc = m_f * 32768 + m_acc / 2; end
      else if (strb[B_ROL]) begin cf = m_acc / 32768; nacc = (m_acc * 2) % 65536 + m_f; end
      else if (strb[B_ADD]) begin s = m_acc + m_gpr; nacc = s % 65536; cf = s / 65536; end
      if (strb[B_LF])         nf = 0;
      else if (strb[B_CF])    nf = 1 - m_f;
      else                    nf = cf;
      m_pc = npc; m_mar = nmar; m_gpr = ngpr; m_opr = nopr; m_acc = nacc; m_f = nf;
   endtask

   initial forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
         m_pc = 0; m_mar = 0; m_gpr = 0; m_opr = 0; m_acc = 0; m_f = 0;
      end else begin
         model_step();
      end
   end

   initial forever begin
      @(negedge clk);
      if (chk_en) begin
         chk("pc", int'(pc_q), m_pc);
         chk("mar", int'(mem_addr), m_mar);
         chk("gpr", int'(mem_wdata), m_gpr);
         chk("opr", int'(c_OPR), m_opr);
         chk("acc", int'(acc_q), m_acc);
         chk("f", int'(c_F), m_f);
         chk("z", int'(c_Z), (m_gpr == 0) ? 1 : 0);
         chk("we", int'(mem_we), int'(strb[B_W]));
         chk("re", int'(mem_re), int'(strb[B_R]));
      end
   end

   // One clock with the given strobes; the bench RAM commits a write after the edge.
   task automatic cyc(input logic [19:0] v);
      logic        wr;
      logic [11:0] wa;
      logic [15:0] wd;
      strb = v;
      @(negedge clk);
      wr = mem_we; wa = mem_addr; wd = mem_wdata;
      @(posedge clk);
      #1;
      if (wr) ram[wa] = wd;
      strb = '0;
   endtask

   task automatic load_gpr(input int v);
      ram[m_mar] = 16'(v);
      cyc(m(B_TMG));
   endtask

   task automatic set_pc(input int v);
      load_gpr(v);
      cyc(m(B_TGPC));
   endtask

   task automatic set_mar(input int v);
      load_gpr(v);
      cyc(m(B_TGMAR));
   endtask

   function automatic logic [19:0] rnd_strobes();
      logic [19:0] v;
      for (int i = 0; i < 20; i++) v[i] = ($urandom_range(0, 3) == 0);
      return v;
   endfunction

   initial begin
      for (int i = 0; i < 4096; i++) ram[i] = 16'($urandom);
      #2;
      chk("rst_pc", int'(pc_q), 0);
      chk("rst_acc", int'(acc_q), 0);
      chk("rst_f", int'(c_F), 0);
      chk("rst_z", int'(c_Z), 1);
      chk("rst_opr", int'(c_OPR), 0);
      chk("rst_we", int'(mem_we), 0);
      #10 rst = 1'b1;
      @(posedge clk);
      #1;
      chk_en = 1'b1;

      // Fetch from address 5
      set_pc(5);
      ram[5] = 16'h9ABC;
      cyc(m(B_TPMAR));
      cyc(m(B_TMG) | m(B_IPC) | m(B_R));
      cyc(m(B_TOPR));
      chk("fetch_mar", int'(mem_addr), 5);
      chk("fetch_gpr", int'(mem_wdata), 16'h9ABC);
      chk("fetch_pc", int'(pc_q), 6);
      chk("fetch_opr", int'(c_OPR), 9);

      // ADD with carry, then complement F
      load_gpr(16'hFFFF);
      cyc(m(B_LACC));
      cyc(m(B_ADD));
      load_gpr(16'h0002);
      cyc(m(B_ADD));
      chk("add_acc", int'(acc_q), 16'h0001);
      chk("add_f", int'(c_F), 1);
      cyc(m(B_CF));
      chk("cf_f", int'(c_F), 0);

      // Rotate through F
      load_gpr(16'h8001);
      cyc(m(B_LACC) | m(B_LF));
      cyc(m(B_ADD));
      cyc(m(B_ROL));
      chk("rol_acc", int'(acc_q), 16'h0002);
      chk("rol_f", int'(c_F), 1);
      cyc(m(B_ROR));
      chk("ror_acc", int'(acc_q), 16'h8001);
      chk("ror_f", int'(c_F), 0);

      // ISZ: increment wraps to zero, Z visible next cycle, zero written back
      set_mar(12'h030);
      load_gpr(16'hFFFF);
      cyc(m(B_IGPR));
      chk("isz_gpr", int'(mem_wdata), 0);
      chk("isz_z", int'(c_Z), 1);
      cyc(m(B_W));
      chk("isz_mem", int'(ram[12'h030]), 0);

      // PC priority and wrap
      set_mar(12'h020);
      set_pc(12'hFFF);
      cyc(m(B_IPC) | m(B_TMPC));
      chk("pc_prio", int'(pc_q), 12'h020);
      set_pc(12'hFFF);
      cyc(m(B_IPC));
      chk("pc_wrap", int'(pc_q), 0);

      // CALL sequence
      set_pc(12'h100);
      cyc(m(B_TPG));
      cyc(m(B_TMPC) | m(B_W));
      cyc(m(B_IPC));
      chk("call_mem", int'(ram[12'h020]), 16'h0100);
      chk("call_pc", int'(pc_q), 12'h021);

      // Asynchronous reset in mid-cycle with strobes active
      load_gpr(16'h1234);
      cyc(m(B_TOPR));
      cyc(m(B_LACC) | m(B_LF));
      cyc(m(B_ADD));
      cyc(m(B_CF));
      chk("pre_acc", int'(acc_q), 16'h1234);
      chk("pre_f", int'(c_F), 1);
      #2;
      strb = m(B_IPC) | m(B_IACC) | m(B_IGPR);
      rst = 1'b0;
      #1;
      chk("arst_acc", int'(acc_q), 0);
      chk("arst_f", int'(c_F), 0);
      chk("arst_z", int'(c_Z), 1);
      chk("arst_opr", int'(c_OPR), 0);
      chk("arst_pc", int'(pc_q), 0);
      @(posedge clk);
      #1;
      chk("hold_pc", int'(pc_q), 0);
      chk("hold_acc", int'(acc_q), 0);
      strb = '0;
      #2 rst = 1'b1;
      @(posedge clk);
      #1;

      // Random strobe combinations against the model
      repeat (1500) cyc(rnd_strobes());

      chk_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
